// File: rtl/riscv_regs_mp_pkg.sv
// riscv_regs_mp_pkg: constants and helpers shared by the multi-port register file.
//   REG_COUNT_DEF : default number of architectural registers (RV32I)
//   IDX_W         : register index width on every port
//   X0_IDX        : hardwired-zero register index
//   idx_valid()   : 1 when an index names a real, writable register
package riscv_regs_mp_pkg;

    localparam int              REG_COUNT_DEF = 32;
    localparam int              IDX_W         = 5;
    localparam logic [IDX_W-1:0] X0_IDX       = '0;

    // x0 and anything at or beyond the register count behave identically:
    // reads give 0, writes vanish, never busy.
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx, input int unsigned rc);
        return (idx != X0_IDX) && (32'(idx) < rc);
    endfunction

endpackage

// File: rtl/riscv_regs_scoreboard.sv
// riscv_regs_scoreboard: per-register busy bits for hazard detection.
//   clock, reset_n   : clock, async active-low reset
//   issue_en/_index  : reserve a destination register
//   issue_ok         : reservation accepted this cycle (combinational)
//   flush            : clear every busy bit at the next edge
//   wr_hit           : per-register "a write lands this cycle" (already resolved)
//   busy_mask        : current busy bits
module riscv_regs_scoreboard
    import riscv_regs_mp_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issue_en,
    input  logic [IDX_W-1:0]     issue_index,
    input  logic                 flush,
    input  logic [REG_COUNT-1:0] wr_hit,
    output logic                 issue_ok,
    output logic [REG_COUNT-1:0] busy_mask
);

    localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 iss_valid;
    logic [IW-1:0]        iss_sel;

    assign iss_valid = idx_valid(issue_index, REG_COUNT);
    assign iss_sel   = issue_index[IW-1:0];

    // A busy destination may be re-reserved in the same cycle its write retires.
    always_comb begin
        issue_ok = issue_en;
        if (iss_valid && busy_q[iss_sel] && !wr_hit[iss_sel])
            issue_ok = 1'b0;
    end

    // Priority, lowest to highest: hold, write clear, issue set, flush.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_ok && iss_valid)
            busy_d[iss_sel] = 1'b1;
        if (flush)
            busy_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/riscv_regs_mp.sv
// riscv_regs_mp: multi-port integer register file with PC and scoreboard.
//   clock, reset_n       : clock, async active-low reset
//   pc_we, pc_next       : PC load; pc_val is the current PC
//   rs_index/rs_data/rs_busy : READ_PORTS packed read ports (combinational)
//   wr_en/wr_index/wr_data   : WRITE_PORTS packed writeback ports
//   issue_en/issue_index/issue_ok : destination reservation
//   flush                : drop all reservations
//   busy_mask            : scoreboard bits
module riscv_regs_mp
    import riscv_regs_mp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_COUNT   = REG_COUNT_DEF,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int BYPASS      = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pc_we,
    input  logic [XLEN-1:0]               pc_next,
    output logic [XLEN-1:0]               pc_val,
    input  logic [READ_PORTS*IDX_W-1:0]   rs_index,
    output logic [READ_PORTS*XLEN-1:0]    rs_data,
    output logic [READ_PORTS-1:0]         rs_busy,
    input  logic [WRITE_PORTS-1:0]        wr_en,
    input  logic [WRITE_PORTS*IDX_W-1:0]  wr_index,
    input  logic [WRITE_PORTS*XLEN-1:0]   wr_data,
    input  logic                          issue_en,
    input  logic [IDX_W-1:0]              issue_index,
    output logic                          issue_ok,
    input  logic                          flush,
    output logic [REG_COUNT-1:0]          busy_mask
);

    localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [REG_COUNT-1:0][XLEN-1:0]   regs_q, regs_d;
    logic [XLEN-1:0]                  pc_q, pc_d;

    logic [WRITE_PORTS-1:0]           wp_vld;
    logic [WRITE_PORTS-1:0][IW-1:0]   wp_sel;
    logic [WRITE_PORTS-1:0][XLEN-1:0] wp_data;

    logic [REG_COUNT-1:0]             wr_hit;
    logic [REG_COUNT-1:0][XLEN-1:0]   wr_val;
    logic [REG_COUNT-1:0]             busy;

    // Writes are gated by reset_n so nothing in flight leaks through the
    // bypass path while the block is held in reset.
    for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wp
        assign wp_vld[w]  = reset_n && wr_en[w] &&
                            idx_valid(wr_index[IDX_W*w +: IDX_W], REG_COUNT);
        assign wp_sel[w]  = wr_index[IDX_W*w +: IW];
        assign wp_data[w] = wr_data[XLEN*w +: XLEN];
    end

    // Ascending scan: the highest-numbered enabled port overwrites earlier ones.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wp_vld[w]) begin
                wr_hit[wp_sel[w]] = 1'b1;
                wr_val[wp_sel[w]] = wp_data[w];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < REG_COUNT; r++)
            if (wr_hit[r]) regs_d[r] = wr_val[r];
    end

    assign pc_d = pc_we ? pc_next : pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
            pc_q   <= '0;
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
        end
    end

    riscv_regs_scoreboard #(.REG_COUNT(REG_COUNT)) u_sb (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_en    (issue_en),
        .issue_index (issue_index),
        .flush       (flush),
        .wr_hit      (wr_hit),
        .issue_ok    (issue_ok),
        .busy_mask   (busy)
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rp
        logic [IDX_W-1:0] ridx;
        logic             rvld;
        logic [IW-1:0]    rsel;
        logic             byp;

        assign ridx = rs_index[IDX_W*p +: IDX_W];
        assign rvld = idx_valid(ridx, REG_COUNT);
        assign rsel = ridx[IW-1:0];
        assign byp  = (BYPASS != 0) && wr_hit[rsel];

        assign rs_data[XLEN*p +: XLEN] = !rvld ? '0 :
                                         byp   ? wr_val[rsel] : regs_q[rsel];
        assign rs_busy[p] = rvld && busy[rsel] && !byp;
    end

    assign pc_val    = pc_q;
    assign busy_mask = busy;

endmodule

// File: tb/tb_riscv_regs_mp.sv
module tb_riscv_regs_mp;

    localparam int XLEN = 32;
    localparam int RC   = 16;
    localparam int RP   = 2;
    localparam int WP   = 2;

    logic             clock;
    logic             reset_n;
    logic             pc_we;
    logic [XLEN-1:0]  pc_next;
    logic [RP*5-1:0]  rs_index;
    logic [WP-1:0]    wr_en;
    logic [WP*5-1:0]  wr_index;
    logic [WP*XLEN-1:0] wr_data;
    logic             issue_en;
    logic [4:0]       issue_index;
    logic             flush;

    logic [XLEN-1:0]    pc_val,   nb_pc_val;
    logic [RP*XLEN-1:0] rs_data,  nb_rs_data;
    logic [RP-1:0]      rs_busy,  nb_rs_busy;
    logic               issue_ok, nb_issue_ok;
    logic [RC-1:0]      busy_mask, nb_busy_mask;

    riscv_regs_mp #(.XLEN(XLEN), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .BYPASS(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .pc_we(pc_we), .pc_next(pc_next), .pc_val(pc_val),
        .rs_index(rs_index), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .issue_en(issue_en), .issue_index(issue_index), .issue_ok(issue_ok),
        .flush(flush), .busy_mask(busy_mask)
    );

    riscv_regs_mp #(.XLEN(XLEN), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .BYPASS(0)) u_nb (
        .clock(clock), .reset_n(reset_n), .pc_we(pc_we), .pc_next(pc_next), .pc_val(nb_pc_val),
        .rs_index(rs_index), .rs_data(nb_rs_data), .rs_busy(nb_rs_busy),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .issue_en(issue_en), .issue_index(issue_index), .issue_ok(nb_issue_ok),
        .flush(flush), .busy_mask(nb_busy_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wi0; logic [31:0] wd0;
        logic [4:0]  wi1; logic [31:0] wd1;
        logic [4:0]  ri0, ri1;
        logic        ie;  logic [4:0]  ii;
        logic        fl;
        logic [31:0] rd0, rd1;
        logic [1:0]  rb;
        logic        iok;
        logic [15:0] bm;
    } vec_t;

    typedef struct {
        logic [31:0] rd0, rd1;
        logic [1:0]  rb;
        logic        iok;
        logic [15:0] bm;
    } exp_t;

    exp_t sb_q[$];
    vec_t vt[17];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic [1:0] we,
                               input logic [4:0] wi0, input logic [31:0] wd0,
                               input logic [4:0] wi1, input logic [31:0] wd1,
                               input logic [4:0] ri0, input logic [4:0] ri1,
                               input logic ie, input logic [4:0] ii, input logic fl,
                               input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic [1:0] rb, input logic iok, input logic [15:0] bm);
        vec_t t;
        t.we = we; t.wi0 = wi0; t.wd0 = wd0; t.wi1 = wi1; t.wd1 = wd1;
        t.ri0 = ri0; t.ri1 = ri1; t.ie = ie; t.ii = ii; t.fl = fl;
        t.rd0 = rd0; t.rd1 = rd1; t.rb = rb; t.iok = iok; t.bm = bm;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        pc_we = 1'b0; pc_next = '0; rs_index = '0;
        wr_en = '0; wr_index = '0; wr_data = '0;
        issue_en = 1'b0; issue_index = '0; flush = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        idle();
        wr_en       = t.we;
        wr_index    = {t.wi1, t.wi0};
        wr_data     = {t.wd1, t.wd0};
        rs_index    = {t.ri1, t.ri0};
        issue_en    = t.ie;
        issue_index = t.ii;
        flush       = t.fl;
    endtask

    initial begin
        exp_t e;

        //            we     wi0    wd0            wi1    wd1            ri0    ri1   ie    ii    fl    rd0            rd1            rb     iok   bm
        vt[0]  = v(2'b01, 5'd1,  32'h1111_0001, 5'd0,  32'h0,         5'd1,  5'd2, 1'b0, 5'd0, 1'b0, 32'h1111_0001, 32'h0,         2'b00, 1'b0, 16'h0000);
        vt[1]  = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd1,  5'd7, 1'b1, 5'd7, 1'b0, 32'h1111_0001, 32'h0,         2'b00, 1'b1, 16'h0080);
        vt[2]  = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0, 1'b1, 5'd7, 1'b0, 32'h0,         32'h0,         2'b01, 1'b0, 16'h0080);
        vt[3]  = v(2'b10, 5'd0,  32'h0,         5'd7,  32'h5,         5'd7,  5'd1, 1'b1, 5'd7, 1'b0, 32'h5,         32'h1111_0001, 2'b00, 1'b1, 16'h0080);
        vt[4]  = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0, 1'b0, 5'd0, 1'b0, 32'h5,         32'h0,         2'b01, 1'b0, 16'h0080);
        vt[5]  = v(2'b11, 5'd0,  32'hDEADBEEF,  5'd20, 32'hDEADBEEF,  5'd0,  5'd20,1'b1, 5'd0, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 16'h0080);
        vt[6]  = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd20,1'b1, 5'd20,1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 16'h0080);
        vt[7]  = v(2'b01, 5'd7,  32'h77,        5'd0,  32'h0,         5'd7,  5'd7, 1'b0, 5'd0, 1'b0, 32'h77,        32'h77,        2'b00, 1'b0, 16'h0000);
        vt[8]  = v(2'b01, 5'd3,  32'h33,        5'd0,  32'h0,         5'd3,  5'd0, 1'b1, 5'd3, 1'b0, 32'h33,        32'h0,         2'b00, 1'b1, 16'h0008);
        vt[9]  = v(2'b10, 5'd0,  32'h0,         5'd4,  32'h44,        5'd3,  5'd4, 1'b1, 5'd4, 1'b0, 32'h33,        32'h44,        2'b01, 1'b1, 16'h0018);
        vt[10] = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd4, 1'b1, 5'd9, 1'b1, 32'h33,        32'h44,        2'b11, 1'b1, 16'h0000);
        vt[11] = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd4, 1'b0, 5'd0, 1'b0, 32'h33,        32'h44,        2'b00, 1'b0, 16'h0000);
        vt[12] = v(2'b11, 5'd5,  32'h11,        5'd5,  32'h22,        5'd5,  5'd5, 1'b0, 5'd0, 1'b0, 32'h22,        32'h22,        2'b00, 1'b0, 16'h0000);
        vt[13] = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd1, 1'b0, 5'd0, 1'b0, 32'h22,        32'h1111_0001, 2'b00, 1'b0, 16'h0000);
        vt[14] = v(2'b11, 5'd15, 32'hF15,       5'd16, 32'hF16,       5'd15, 5'd16,1'b1, 5'd15,1'b0, 32'hF15,       32'h0,         2'b00, 1'b1, 16'h8000);
        vt[15] = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd15, 5'd16,1'b1, 5'd16,1'b0, 32'hF15,       32'h0,         2'b01, 1'b1, 16'h8000);
        vt[16] = v(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd15, 5'd0, 1'b1, 5'd15,1'b0, 32'hF15,       32'h0,         2'b01, 1'b0, 16'h8000);

        // Reset state
        idle();
        reset_n = 1'b0;
        #3;
        chk("reset_pc",   64'(pc_val),    64'h0);
        chk("reset_busy", 64'(busy_mask), 64'h0);
        chk("reset_rs",   64'(rs_data),   64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Table vectors: expectations queued at drive time, retired at sample time
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            apply(vt[i]);
            sb_q.push_back('{rd0: vt[i].rd0, rd1: vt[i].rd1, rb: vt[i].rb, iok: vt[i].iok, bm: vt[i].bm});
            #2;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_rd0", i), 64'(rs_data[31:0]),  64'(e.rd0));
            chk($sformatf("v%0d_rd1", i), 64'(rs_data[63:32]), 64'(e.rd1));
            chk($sformatf("v%0d_rb",  i), 64'(rs_busy),        64'(e.rb));
            chk($sformatf("v%0d_iok", i), 64'(issue_ok),       64'(e.iok));
            @(posedge clock); #1;
            chk($sformatf("v%0d_bm",  i), 64'(busy_mask),      64'(e.bm));
        end

        // BYPASS=0 sees only stored state
        @(negedge clock); idle(); issue_en = 1'b1; issue_index = 5'd6;
        @(posedge clock); #1;
        chk("nb_issue_busy", 64'(busy_mask), 64'h8040);
        @(negedge clock); idle();
        wr_en = 2'b01; wr_index = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66}; rs_index = {5'd6, 5'd6};
        #2;
        chk("byp_rd",   64'(rs_data[31:0]),    64'h66);
        chk("byp_rb",   64'(rs_busy[0]),       64'h0);
        chk("nb_rd",    64'(nb_rs_data[31:0]), 64'h0);
        chk("nb_rb",    64'(nb_rs_busy[0]),    64'h1);
        @(posedge clock); #1;
        chk("nb_bm", 64'(nb_busy_mask), 64'h8000);
        @(negedge clock); idle(); rs_index = {5'd6, 5'd6};
        #2;
        chk("nb_rd_after", 64'(nb_rs_data[31:0]), 64'h66);
        chk("nb_rb_after", 64'(nb_rs_busy[0]),    64'h0);

        // PC load, hold, reload
        @(negedge clock); idle(); pc_we = 1'b1; pc_next = 32'hFFFF_FFFC;
        @(posedge clock); #1;
        chk("pc_load", 64'(pc_val), 64'hFFFF_FFFC);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); idle(); pc_next = 32'h1234;
            @(posedge clock); #1;
            chk($sformatf("pc_hold%0d", k), 64'(pc_val), 64'hFFFF_FFFC);
        end
        @(negedge clock); idle(); pc_we = 1'b1; pc_next = 32'h0;
        @(posedge clock); #1;
        chk("pc_zero", 64'(pc_val), 64'h0);

        // Mid-cycle reset with busy bits, PC and an in-flight write
        @(negedge clock); idle(); pc_we = 1'b1; pc_next = 32'hA5A5_0000;
        issue_en = 1'b1; issue_index = 5'd2;
        @(posedge clock); #1;
        chk("pre_rst_bm", 64'(busy_mask), 64'h8004);
        chk("pre_rst_pc", 64'(pc_val),    64'hA5A5_0000);
        @(negedge clock); idle();
        rs_index = {5'd4, 5'd3}; wr_en = 2'b01; wr_index = {5'd0, 5'd3}; wr_data = {32'h0, 32'h99};
        issue_en = 1'b1; issue_index = 5'd2;
        #2; reset_n = 1'b0; #1;
        chk("rst_bm",  64'(busy_mask), 64'h0);
        chk("rst_pc",  64'(pc_val),    64'h0);
        chk("rst_rs",  64'(rs_data),   64'h0);
        chk("rst_iok", 64'(issue_ok),  64'h1);
        @(posedge clock); #1;
        chk("rst_edge_rs", 64'(rs_data),   64'h0);
        chk("rst_edge_bm", 64'(busy_mask), 64'h0);
        @(negedge clock); idle(); reset_n = 1'b1; rs_index = {5'd4, 5'd3};
        #2;
        chk("post_rst_rs", 64'(rs_data), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
